// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared widths, control bit map and stage state encoding
package pipeline_pkg;

  localparam int RESULT_W     = 32;
  localparam int REG_DEST_W   = 5;
  localparam int JUMP_ADDR_W  = 11;
  localparam int TRUNK_MODE_W = 3;

  // EX/MEM payload: result + destination register + jump target
  localparam int EXMEM_DATA_W = RESULT_W + REG_DEST_W + JUMP_ADDR_W;

  localparam int CTRL_MEMTOREG = 0;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_TRUNK_LO = 5;
  localparam int CTRL_TRUNK_HI = CTRL_TRUNK_LO + TRUNK_MODE_W - 1;
  localparam int CTRL_W        = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - one valid+ctrl+data holding register with load and clear
module pipe_entry #(
  parameter int DATA_W = 48,
  parameter int CTRL_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // clear beats load so a flushed entry never keeps a beat or stale control; data survives clear
  always_ff @(negedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= load_ctrl;
      data  <= load_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - handshaked pipeline stage register with optional skid entry
module pipe_stage_reg
  import pipeline_pkg::*;
#(
  parameter int DATA_W = pipeline_pkg::EXMEM_DATA_W,
  parameter int CTRL_W = pipeline_pkg::CTRL_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_count
);

  stage_state_e state, state_next;

  logic              accept, emit;
  logic              main_load, main_clear, main_from_skid;
  logic              skid_load, skid_clear;
  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data, main_load_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_load_ctrl;
  logic [CNT_W-1:0]  stall_q;

  assign accept = in_valid && in_ready;
  assign emit   = main_valid && out_ready;

  // state register; all stage state moves on the falling edge like the neighbouring registers
  always_ff @(negedge clock) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_next;
  end

  // next state: flush empties the stage regardless of any accept or emit at the same edge
  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: if (accept) state_next = ST_ONE;
      ST_ONE: begin
        if (accept && !emit && (SKID != 0)) state_next = ST_TWO;
        else if (!accept && emit)           state_next = ST_EMPTY;
      end
      ST_TWO:   if (emit) state_next = ST_ONE;
      default:  state_next = ST_EMPTY;
    endcase
    if (flush) state_next = ST_EMPTY;
  end

  // entry controls: the input goes to main when main is free or draining, else to skid
  always_comb begin
    main_load      = 1'b0;
    main_clear     = flush;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = flush;
    case (state)
      ST_EMPTY: main_load = accept;
      ST_ONE: begin
        if (accept && emit) main_load  = 1'b1;
        else if (accept)    skid_load  = 1'b1;
        else if (emit)      main_clear = 1'b1;
      end
      ST_TWO: begin
        if (emit) begin
          main_load      = 1'b1;
          main_from_skid = skid_valid;
          skid_clear     = 1'b1;
        end
      end
      default: main_clear = 1'b1;
    endcase
  end

  assign main_load_data = main_from_skid ? skid_data : in_data;
  assign main_load_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clock     (clock),
    .reset     (reset),
    .clear     (main_clear),
    .load      (main_load),
    .load_data (main_load_data),
    .load_ctrl (main_load_ctrl),
    .valid     (main_valid),
    .data      (main_data),
    .ctrl      (main_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic ready_q;

      pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clock     (clock),
        .reset     (reset),
        .clear     (skid_clear),
        .load      (skid_load),
        .load_data (in_data),
        .load_ctrl (in_ctrl),
        .valid     (skid_valid),
        .data      (skid_data),
        .ctrl      (skid_ctrl)
      );

      // ready is registered so upstream never sees a path from out_ready
      always_ff @(negedge clock) begin
        if (reset) ready_q <= 1'b0;
        else       ready_q <= (state_next != ST_TWO);
      end

      assign in_ready = ready_q;
    end else begin : g_pass
      logic live_q;

      assign skid_valid = 1'b0;
      assign skid_data  = '0;
      assign skid_ctrl  = '0;

      // holds ready low through the reset edge, as the registered variant does
      always_ff @(negedge clock) begin
        live_q <= !reset;
      end

      assign in_ready = live_q && (!main_valid || out_ready);
    end
  endgenerate

  // stall counter: counts held-off edges, sticks at all-ones, cleared only by reset
  always_ff @(negedge clock) begin
    if (reset)                                          stall_q <= '0;
    else if (main_valid && !out_ready && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
  end

  assign out_valid   = main_valid;
  assign out_data    = main_data;
  assign out_ctrl    = main_valid ? main_ctrl : '0;
  assign stall_count = stall_q;

endmodule
